// File: rtl/imm_enc_pkg.sv
// Shared opcode constants, format classes and the opcode classifier used by imm_encoder.
package imm_enc_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_t;

    function automatic fmt_t opcode_fmt(input logic [6:0] op);
        fmt_t f;
        case (op)
            OP_LUI, OP_AUIPC:         f = FMT_U;
            OP_STORE:                 f = FMT_S;
            OP_JALR, OP_LOAD, OP_OPIMM: f = FMT_I;
            OP_JAL:                   f = FMT_J;
            default:                  f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_range_chk.sv
// Combinational immediate range check: is imm exactly representable in the format's field?
// Compiled only when IMM_CHECK_EN is defined.
`ifdef IMM_CHECK_EN
module imm_range_chk
    import imm_enc_pkg::*;
(
    input  fmt_t        fmt,
    input  logic [31:0] imm,
    output logic        ok
);

    always_comb begin
        ok = 1'b0;
        case (fmt)
            FMT_I, FMT_S: ok = (imm[31:11] == {21{imm[11]}});
            FMT_U:        ok = (imm[11:0] == 12'h000);
            FMT_J:        ok = !imm[0] && (imm[31:20] == {12{imm[20]}});
            default:      ok = 1'b0;
        endcase
    end

endmodule
`endif

// File: rtl/imm_encoder.sv
// RV32I instruction encoder (I/S/U/J): 2-stage valid/ready pipeline, full throughput.
// Define IMM_CHECK_EN to enable immediate range checking, out_err and err_cnt.
module imm_encoder
    import imm_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] err_cnt
);

    logic        s1_valid_q;
    fmt_t        s1_fmt_q;
    logic [6:0]  s1_opcode_q;
    logic [4:0]  s1_rd_q;
    logic [2:0]  s1_funct3_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [31:0] s1_imm_q;

    logic        s2_valid_q;
    logic [31:0] s2_inst_q;

    logic        s2_adv;
    logic        s1_load;
    logic [31:0] packed_inst;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign s1_load  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= FMT_BAD;
            s1_opcode_q <= 7'd0;
            s1_rd_q     <= 5'd0;
            s1_funct3_q <= 3'd0;
            s1_rs1_q    <= 5'd0;
            s1_rs2_q    <= 5'd0;
            s1_imm_q    <= 32'd0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (s1_load) begin
                s1_fmt_q    <= opcode_fmt(in_opcode);
                s1_opcode_q <= in_opcode;
                s1_rd_q     <= in_rd;
                s1_funct3_q <= in_funct3;
                s1_rs1_q    <= in_rs1;
                s1_rs2_q    <= in_rs2;
                s1_imm_q    <= in_imm;
            end
        end
    end

    // Immediate bits outside the format's field are dropped by the slices below.
    always_comb begin
        packed_inst = NOP;
        case (s1_fmt_q)
            FMT_U: packed_inst = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
            FMT_S: packed_inst = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                  s1_imm_q[4:0], s1_opcode_q};
            FMT_I: packed_inst = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            FMT_J: packed_inst = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                                  s1_rd_q, s1_opcode_q};
            default: packed_inst = NOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_inst_q  <= 32'd0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_inst_q <= packed_inst;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;

`ifdef IMM_CHECK_EN
    logic        chk_ok;
    logic        s1_ok_q;
    logic        s2_err_q;
    logic [15:0] err_cnt_q;

    imm_range_chk u_chk (
        .fmt(opcode_fmt(in_opcode)),
        .imm(in_imm),
        .ok (chk_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ok_q   <= 1'b0;
            s2_err_q  <= 1'b0;
            err_cnt_q <= 16'd0;
        end else begin
            if (s1_load) begin
                s1_ok_q <= chk_ok;
            end
            if (s2_adv && s1_valid_q) begin
                s2_err_q <= !s1_ok_q;
            end
            if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign out_err = s2_err_q;
    assign err_cnt = err_cnt_q;
`else
    assign out_err = 1'b0;
    assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors, backpressure, mid-flight reset and
// randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = 7'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [31:0] in_imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] err_cnt;

    imm_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_opcode(in_opcode),
        .in_rd    (in_rd),
        .in_funct3(in_funct3),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_imm   (in_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst (out_inst),
        .out_err  (out_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_errcnt = 0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          tag;
    } exp_t;

    exp_t q[$];

    logic [6:0] op_tbl [0:6] = '{7'b0110111, 7'b0010111, 7'b0100011, 7'b1100111,
                                 7'b0000011, 7'b0010011, 7'b1101111};

    // Reference packing built from shifts and masks on the whole immediate.
    function automatic logic [31:0] ref_inst(input logic [6:0] op, input logic [4:0] rd,
                                             input logic [2:0] f3, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] o, d, f, a, b;
        o = 32'(op); d = 32'(rd) << 7; f = 32'(f3) << 12; a = 32'(rs1) << 15; b = 32'(rs2) << 20;
        case (op)
            7'b0110111, 7'b0010111: return (imm & 32'hFFFF_F000) | d | o;
            7'b0100011: return (((imm >> 5) & 32'h7F) << 25) | b | a | f
                               | ((imm & 32'h1F) << 7) | o;
            7'b1100111, 7'b0000011, 7'b0010011: return ((imm & 32'hFFF) << 20) | a | f | d | o;
            7'b1101111: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                               | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                               | d | o;
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic logic ref_ok(input logic [6:0] op, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (op)
            7'b0100011, 7'b1100111, 7'b0000011, 7'b0010011: return (s >= -2048) && (s <= 2047);
            7'b0110111, 7'b0010111: return (imm % 4096) == 0;
            7'b1101111: return ((imm % 2) == 0) && (s >= -(1 << 20)) && (s < (1 << 20));
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_err(input logic [6:0] op, input logic [31:0] imm);
`ifdef IMM_CHECK_EN
        return !ref_ok(op, imm);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] dec_j(input logic [31:0] w);
        logic [20:0] t;
        t = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        return {{11{t[20]}}, t};
    endfunction

    function automatic logic [15:0] errcnt_exp();
        return (exp_errcnt > 65535) ? 16'hFFFF : 16'(exp_errcnt);
    endfunction

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        in_opcode = op; in_rd = rd; in_funct3 = f3; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic rand_fields();
        logic [31:0] r;
        logic [31:0] imm;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = {{20{r[11]}}, r[11:0]};
            2: imm = {r[31:12], 12'h000};
            default: imm = {{11{r[20]}}, r[20:1], 1'b0};
        endcase
        if ($urandom_range(0, 7) == 7) op = 7'($urandom);
        else op = op_tbl[$urandom_range(0, 6)];
        drive(op, 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), imm);
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_inst !== 32'd0 || out_err !== 1'b0
            || err_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_values: rdy=%b ov=%b inst=%h err=%b cnt=%h, want 1 0 0 0 0",
                     in_ready, out_valid, out_inst, out_err, err_cnt);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset: rdy=%b ov=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    // Single word into an empty pipe: out_valid low after the accept edge, high after the next.
    task automatic single_word(input string name, input logic [6:0] op, input logic [4:0] rd,
                               input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic [31:0] want_inst,
                               input logic want_err);
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1;
        drive(op, rd, f3, rs1, rs2, imm);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL %s_early_valid: got %b want 0", name, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_inst !== want_inst || out_err !== want_err) begin
            n_errors++;
            $display("FAIL %s: ov=%b inst=%h err=%b, want 1 %h %b", name, out_valid, out_inst,
                     out_err, want_inst, want_err);
        end
        if (op == 7'b1101111) begin
            n_checks++;
            if (dec_j(out_inst) !== imm) begin
                n_errors++;
                $display("FAIL %s_roundtrip: got %h want %h", name, dec_j(out_inst), imm);
            end
        end
        @(posedge clk); #1;
        if (want_err) exp_errcnt++;
        n_checks++;
        if (err_cnt !== errcnt_exp()) begin
            n_errors++; $display("FAIL %s_err_cnt: got %0d want %0d", name, err_cnt, errcnt_exp());
        end
    endtask

    task automatic test_vectors();
        logic chk;
`ifdef IMM_CHECK_EN
        chk = 1'b1;
`else
        chk = 1'b0;
`endif
        single_word("addi_m1", 7'b0010011, 5'd1, 3'd0, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
        single_word("sw", 7'b0100011, 5'd0, 3'b010, 5'd2, 5'd5, 32'h8, 32'h0051_2423, 1'b0);
        single_word("lui", 7'b0110111, 5'd3, 3'd0, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_51B7, 1'b0);
        single_word("jal", 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 32'h800, 32'h0010_00EF, 1'b0);
        single_word("addi_ovf", 7'b0010011, 5'd1, 3'd0, 5'd2, 5'd0, 32'h800, 32'h8001_0093, chk);
        single_word("bad_op", 7'b1100011, 5'd1, 3'd0, 5'd2, 5'd3, 32'h4, 32'h0000_0013, chk);
    endtask

    task automatic test_backpressure();
        exp_t w[3];
        logic [6:0] op [3];
        logic [31:0] imm [3];
        for (int i = 0; i < 3; i++) begin
            op[i] = op_tbl[$urandom_range(0, 6)];
            imm[i] = $urandom;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            drive(op[i], 5'(i + 1), 3'(i), 5'(i + 4), 5'(i + 9), imm[i]);
            w[i].inst = ref_inst(op[i], 5'(i + 1), 3'(i), 5'(i + 4), 5'(i + 9), imm[i]);
            w[i].err = ref_err(op[i], imm[i]);
            if (i < 2) begin
                @(negedge clk);
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_errors++; $display("FAIL bp_accept%0d: in_ready=%b want 1", i, in_ready);
                end
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== w[0].inst
                || out_err !== w[0].err) begin
                n_errors++;
                $display("FAIL bp_hold%0d: rdy=%b ov=%b inst=%h err=%b, want 0 1 %h %b", k,
                         in_ready, out_valid, out_inst, out_err, w[0].inst, w[0].err);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_inst !== w[i].inst || out_err !== w[i].err
                || (i == 0 && in_ready !== 1'b1)) begin
                n_errors++;
                $display("FAIL bp_order%0d: ov=%b inst=%h err=%b rdy=%b, want 1 %h %b", i,
                         out_valid, out_inst, out_err, in_ready, w[i].inst, w[i].err);
            end
            if (w[i].err) exp_errcnt++;
            @(posedge clk); #1 in_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || err_cnt !== errcnt_exp()) begin
            n_errors++;
            $display("FAIL bp_drain: ov=%b cnt=%0d, want 0 %0d", out_valid, err_cnt, errcnt_exp());
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            drive(7'b1100011, 5'd1, 3'd0, 5'd1, 5'd1, 32'h1);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_errcnt = 0;
        n_checks++;
        if (out_valid !== 1'b0 || err_cnt !== 16'd0 || in_ready !== 1'b1 || out_inst !== 32'd0) begin
            n_errors++;
            $display("FAIL rst_flight: ov=%b cnt=%0d rdy=%b inst=%h, want 0 0 1 0", out_valid,
                     err_cnt, in_ready, out_inst);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1 out_ready = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_release: rdy=%b ov=%b, want 1 0", in_ready, out_valid);
        end
        single_word("after_rst", 7'b0010011, 5'd7, 3'd4, 5'd8, 5'd0, 32'h7FF, 32'h7FF4_4393, 1'b0);
    endtask

    task automatic test_random(input int n_cycles);
        exp_t e;
        logic exp_rdy, exp_ov;
        for (int c = 0; c < n_cycles; c++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 3) != 0);
            rand_fields();
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_rdy = !(q.size() == 2 && !out_ready);
            exp_ov = (q.size() > 0) && (q[0].tag + 2 <= c);
            n_checks++;
            if (in_ready !== exp_rdy || out_valid !== exp_ov || err_cnt !== errcnt_exp()) begin
                n_errors++;
                $display("FAIL rand_ctl c=%0d: rdy=%b ov=%b cnt=%0d, want %b %b %0d", c, in_ready,
                         out_valid, err_cnt, exp_rdy, exp_ov, errcnt_exp());
            end
            if (exp_ov) begin
                n_checks++;
                if (out_inst !== q[0].inst || out_err !== q[0].err) begin
                    n_errors++;
                    $display("FAIL rand_data c=%0d: inst=%h err=%b, want %h %b", c, out_inst,
                             out_err, q[0].inst, q[0].err);
                end
                if (out_ready) begin
                    e = q.pop_front();
                    if (e.err) exp_errcnt++;
                end
            end
            if (in_valid && exp_rdy) begin
                e.inst = ref_inst(in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_imm);
                e.err = ref_err(in_opcode, in_imm);
                e.tag = c;
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 8 && q.size() > 0; k++) begin
            @(negedge clk);
            if (out_valid) begin
                e = q.pop_front();
                if (e.err) exp_errcnt++;
                n_checks++;
                if (out_inst !== e.inst || out_err !== e.err) begin
                    n_errors++;
                    $display("FAIL rand_drain: inst=%h err=%b, want %h %b", out_inst, out_err,
                             e.inst, e.err);
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (q.size() != 0 || err_cnt !== errcnt_exp()) begin
            n_errors++;
            $display("FAIL rand_final: left=%0d cnt=%0d, want 0 %0d", q.size(), err_cnt,
                     errcnt_exp());
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_midflight();
        test_random(600);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
